// File: rtl/alu_rmw_ctrl_if.sv
// Memory bus between the RMW controller (master) and the memory (slave).
interface alu_rmw_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/alu_rmw_ctrl.sv
// 6502-style read-modify-write sequencer. It reads a byte, lets an external
// ALU shift, rotate, increment or decrement it, writes the original byte back
// (dummy write) and then writes the new byte.
module alu_rmw_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic              c_in,
  output logic              busy,
  output logic              done,
  alu_rmw_ctrl_if.master    bus,
  output logic [3:0]        alu_cmd,
  output logic              alu_ci,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  input  logic [7:0]        alu_result,
  input  logic              alu_no,
  input  logic              alu_zo,
  input  logic              alu_co,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_c_we,
  output logic [7:0]        result
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    MODIFY = 3'd2,
    WR_OLD = 3'd3,
    WR_NEW = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        opnd_q;
  logic [7:0]        result_q;
  logic              n_q, z_q, c_q;
  logic              flag_n_q, flag_z_q, flag_c_q;
  logic [3:0]        cmd_q, cmd_d;
  logic [7:0]        b_q, b_d;
  logic              ci_q, ci_d;
  logic              accept;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; mem_ack only matters in the states that drive a bus request.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (op <= 3'd5)) begin
          accept  = 1'b1;
          state_d = READ;
        end
      end
      READ:    if (bus.mem_ack) state_d = MODIFY;
      MODIFY:  state_d = WR_OLD;
      WR_OLD:  if (bus.mem_ack) state_d = WR_NEW;
      WR_NEW:  if (bus.mem_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU command decode, registered at acceptance so the ALU inputs follow the
  // latched op rather than the live op port.
  always_comb begin
    cmd_d = 4'd0;
    b_d   = 8'd0;
    ci_d  = 1'b0;
    case (op)
      3'd0: cmd_d = 4'd5;
      3'd1: cmd_d = 4'd6;
      3'd2: begin cmd_d = 4'd7; ci_d = c_in; end
      3'd3: begin cmd_d = 4'd8; ci_d = c_in; end
      3'd4: begin cmd_d = 4'd0; b_d = 8'd1; end
      3'd5: begin cmd_d = 4'd1; b_d = 8'd1; end
      default: ;
    endcase
  end

  // Datapath: request latch, operand capture, ALU capture, flag publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      addr_q   <= '0;
      cmd_q    <= '0;
      b_q      <= '0;
      ci_q     <= 1'b0;
      opnd_q   <= '0;
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= op;
        addr_q <= addr;
        cmd_q  <= cmd_d;
        b_q    <= b_d;
        ci_q   <= ci_d;
      end
      if (state_q == READ && bus.mem_ack) opnd_q <= bus.mem_rdata;
      if (state_q == MODIFY) begin
        result_q <= alu_result;
        n_q      <= alu_no;
        z_q      <= alu_zo;
        c_q      <= alu_co;
      end
      // Flags become visible on entry to DONE and hold until the next one.
      if (state_q == WR_NEW && bus.mem_ack) begin
        flag_n_q <= n_q;
        flag_z_q <= z_q;
        flag_c_q <= c_q;
      end
    end
  end

  // Bus outputs: read and write are decoded from disjoint states.
  always_comb begin
    bus.mem_addr  = addr_q;
    bus.mem_rd    = (state_q == READ);
    bus.mem_wr    = (state_q == WR_OLD) || (state_q == WR_NEW);
    bus.mem_wdata = 8'd0;
    if (state_q == WR_OLD) bus.mem_wdata = opnd_q;
    if (state_q == WR_NEW) bus.mem_wdata = result_q;
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign alu_cmd   = cmd_q;
  assign alu_b     = b_q;
  assign alu_ci    = ci_q;
  assign alu_a     = opnd_q;
  assign result    = result_q;
  assign flag_n    = flag_n_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  // Only the shifts and rotates are allowed to update the CPU carry.
  assign flag_c_we = (state_q == DONE) && (op_q < 3'd4);

endmodule
